// File: rtl/rom_reader_pkg.sv
// Shared types and default parameters for the ROM stream reader.
package rom_reader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } reader_state_t;

  localparam int DEF_ADDR_W       = 16;
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_READ_LATENCY = 2;
  localparam int DEF_FIFO_DEPTH   = 4;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; DEPTH must be a power of 2.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [AW:0]      o_count,
  output logic             o_empty,
  output logic             o_full
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clock) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Upstream credit accounting must keep this from ever firing.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      assert (!(i_push && o_full && !i_pop)) else $error("sync_fifo overflow");
    end
  end

endmodule

// File: rtl/rom_stream_reader.sv
// Streams `length` ROM bytes from `base_addr` as valid/ready, hiding the fixed ROM latency.
//   state  | meaning
//   IDLE   | waiting for start
//   FETCH  | issuing reads while credits allow
//   DRAIN  | all reads issued, waiting for pipe and FIFO to empty
//   FINISH | one-cycle done pulse
module rom_stream_reader
  import rom_reader_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int READ_LATENCY = DEF_READ_LATENCY,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

  reader_state_t           r_state;
  reader_state_t           w_state_nxt;
  logic [ADDR_W-1:0]       r_addr;
  logic [15:0]             r_remaining;
  logic [READ_LATENCY-1:0] r_vpipe;
  logic [READ_LATENCY-1:0] r_lpipe;
  logic [CNT_W-1:0]        r_outstanding;
  logic [CNT_W-1:0]        w_outstanding_nxt;
  logic [READ_LATENCY:0]   w_vin;
  logic [READ_LATENCY:0]   w_lin;
  logic [CNT_W:0]          w_credit_used;
  logic                    w_issue;
  logic                    w_issue_last;
  logic                    w_tail;
  logic                    w_pop;
  logic [DATA_W:0]         w_fifo_data;
  logic [CNT_W-1:0]        w_fifo_count;
  logic                    w_fifo_empty;
  logic                    w_fifo_full;

  assign w_credit_used = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
  assign w_issue       = (r_state == FETCH) && (w_credit_used < DEPTH_C);
  assign w_issue_last  = w_issue && (r_remaining == 16'd1);
  assign w_vin         = {r_vpipe, w_issue};
  assign w_lin         = {r_lpipe, w_issue_last};
  assign w_tail        = r_vpipe[READ_LATENCY-1];

  assign busy        = (r_state != IDLE);
  assign done        = (r_state == FINISH);
  assign rom_address = r_addr;
  assign out_valid   = !w_fifo_empty;
  assign out_data    = w_fifo_empty ? '0 : w_fifo_data[DATA_W-1:0];
  assign out_last    = !w_fifo_empty && w_fifo_data[DATA_W];
  assign w_pop       = out_valid && out_ready;

  always_comb begin
    w_outstanding_nxt = r_outstanding;
    case ({w_issue, w_tail})
      2'b10:   w_outstanding_nxt = r_outstanding + CNT_W'(1);
      2'b01:   w_outstanding_nxt = r_outstanding - CNT_W'(1);
      default: w_outstanding_nxt = r_outstanding;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:   if (start) w_state_nxt = (length != 16'd0) ? FETCH : FINISH;
      FETCH:  if (w_issue_last) w_state_nxt = DRAIN;
      DRAIN:  if (r_outstanding == '0 && w_fifo_empty) w_state_nxt = FINISH;
      FINISH: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_remaining   <= '0;
      r_vpipe       <= '0;
      r_lpipe       <= '0;
      r_outstanding <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && start && length != 16'd0) begin
        r_addr      <= base_addr;
        r_remaining <= length;
      end else if (w_issue) begin
        r_addr      <= r_addr + ADDR_W'(1);
        r_remaining <= r_remaining - 16'd1;
      end
      r_vpipe       <= w_vin[READ_LATENCY-1:0];
      r_lpipe       <= w_lin[READ_LATENCY-1:0];
      r_outstanding <= w_outstanding_nxt;
    end
  end

  // Entry = {last tag, data}; the pipe tail marks the cycle rom_q is valid.
  sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (w_tail),
    .i_data  ({r_lpipe[READ_LATENCY-1], rom_q}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  logic w_unused;
  assign w_unused = w_fifo_full;

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader with a latency-2 behavioural ROM (q = addr lo ^ addr hi).
module tb_rom_stream_reader;

  localparam int L = 2;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic [15:0] rom_address;
  logic [7:0]  rom_q;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;

  int n_checks = 0;
  int n_errors = 0;

  rom_stream_reader #(
    .ADDR_W (16), .DATA_W (8), .READ_LATENCY (L), .FIFO_DEPTH (4)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .base_addr   (base_addr),
    .length      (length),
    .busy        (busy),
    .done        (done),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] rom_f(input logic [15:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  logic [15:0] a_pipe [L];
  always @(posedge clock) begin
    a_pipe[0] <= rom_address;
    for (int i = 1; i < L; i++) a_pipe[i] <= a_pipe[i-1];
  end
  assign rom_q = rom_f(a_pipe[L-1]);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Cycle 0 is the start cycle; out_ready is low in cycles rlo..rhi (none when rlo > rhi).
  task automatic run_cmd(input logic [15:0] base, input logic [15:0] len,
                         input int rlo, input int rhi, input int stray_c,
                         input int exp_done, input int exp_last);
    int n_got, last_c, done_c, first_c;
    bit no_bp;
    logic [15:0] exp_a;
    n_got = 0; last_c = -1; done_c = -1; first_c = -1;
    no_bp = (rlo > rhi);
    start = 1'b1; base_addr = base; length = len; out_ready = 1'b1;
    for (int c = 1; c <= 60 && done_c < 0; c++) begin
      tick();
      start = 1'b0;
      if (c == stray_c) begin
        start = 1'b1; base_addr = 16'hABCD; length = 16'd3;
      end
      out_ready = !(c >= rlo && c <= rhi);
      if (no_bp && c <= int'(len)) begin
        exp_a = base + 16'(c - 1);
        check("rom_address", 32'(rom_address), 32'(exp_a));
      end
      if (!no_bp && c == rhi) check("stall_address", 32'(rom_address), 32'(base + 16'd4));
      check("busy", 32'(busy), 1);
      check("spurious_valid", 32'(out_valid && n_got >= int'(len)), 0);
      if (out_valid && out_ready) begin
        check("out_data", 32'(out_data), 32'(rom_f(base + 16'(n_got))));
        check("out_last", 32'(out_last), 32'(n_got == int'(len) - 1));
        if (n_got == 0) first_c = c;
        if (out_last) last_c = c;
        n_got++;
      end
      if (done) done_c = c;
    end
    start = 1'b0;
    out_ready = 1'b1;
    check("done_cycle", 32'(done_c), 32'(exp_done));
    check("byte_count", 32'(n_got), 32'(len));
    check("last_cycle", 32'(last_c), 32'(exp_last));
    if (no_bp && len != 16'd0) check("first_cycle", 32'(first_c), 32'(2 + L));
    tick();
    check("done_width", 32'(done), 0);
    check("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
    #3;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_last", 32'(out_last), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_address", 32'(rom_address), 0);
    tick();
    reset_n = 1'b1;
    tick();
    tick();

    run_cmd(16'h0010, 16'd4, 1, 0, -1, 9, 7);
    run_cmd(16'hFFFE, 16'd4, 1, 0, -1, 9, 7);
    run_cmd(16'h0020, 16'd10, 3, 12, -1, 24, 22);
    run_cmd(16'h0040, 16'd0, 1, 0, -1, 1, -1);
    run_cmd(16'h0050, 16'd8, 1, 0, 3, 13, 11);

    // Reset after three of eight bytes have been delivered.
    start = 1'b1; base_addr = 16'h0100; length = 16'd8; out_ready = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      start = 1'b0;
    end
    check("pre_rst_valid", 32'(out_valid), 1);
    check("pre_rst_data", 32'(out_data), 32'h03);
    tick();
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_last", 32'(out_last), 0);
    check("mid_rst_data", 32'(out_data), 0);
    check("mid_rst_address", 32'(rom_address), 0);
    tick();
    reset_n = 1'b1;
    tick();
    run_cmd(16'h0200, 16'd2, 1, 0, -1, 7, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
